sync_fifo_param: RTL

Parametrised single-clock FIFO: the general-purpose buffering element between producer and consumer stages sharing one clock. Depth, width, and almost-full/almost-empty thresholds are parameters. Outputs are registered status flags, an occupancy count, and overflow/underflow pulses. A compile-time option selects first-word-fall-through (FWFT) read behaviour.

---
 rtl/sync_fifo_pkg.sv | 34 +++
 rtl/sync_fifo_param_if.sv | 43 ++++
 rtl/sync_fifo_mem.sv | 57 +++++
 rtl/sync_fifo_param.sv | 125 ++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// ---------------------------------------------------------------------------
// sync_fifo_pkg
// Purpose : shared helpers for the parametrised single-clock FIFO.
//   ptr_width(depth)   - bits needed to address DEPTH entries
//   count_width(depth) - bits needed to hold an occupancy of 0..DEPTH
//   params_ok(...)     - legality check for the FIFO parameter set
// Ports   : none (package)
// Options : none here; the FWFT read mode is selected in the top and the RAM
//           with the SYNC_FIFO_FWFT_EN macro.
// ---------------------------------------------------------------------------
package sync_fifo_pkg;

  // Address width for the read/write pointers; never narrower than 1 bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy needs one extra bit so that "completely full" is representable.
  function automatic int count_width(input int depth);
    return ptr_width(depth) + 1;
  endfunction

  // DEPTH must be a power of two so the pointers can wrap for free.
  // The thresholds must land inside the range the count can actually reach.
  function automatic bit params_ok(input int dataWidth, input int depth,
                                   input int afullThresh, input int aemptyThresh);
    bit isPow2;
    isPow2 = (depth >= 2) && ((depth & (depth - 1)) == 0);
    return isPow2 && (dataWidth >= 1) &&
           (afullThresh >= 1) && (afullThresh <= depth) &&
           (aemptyThresh >= 0) && (aemptyThresh <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// ---------------------------------------------------------------------------
// sync_fifo_param_if
// Purpose : bundles the producer/consumer handshake of the FIFO.
// Signals : wr_en, wr_data, rd_en            (driven by the user / master)
//           rd_data, rd_valid, full, empty,
//           almost_full, almost_empty, count,
//           overflow, underflow               (driven by the FIFO / slave)
// Modports: master = FIFO user, slave = FIFO itself.
// ---------------------------------------------------------------------------
interface sync_fifo_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  import sync_fifo_pkg::*;

  localparam int CW = count_width(DEPTH);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// ---------------------------------------------------------------------------
// sync_fifo_mem
// Purpose : simple dual-port RAM, DEPTH x DATA_WIDTH, synchronous write.
//           Read port is registered by default (rd_data resets to 0) and
//           asynchronous when SYNC_FIFO_FWFT_EN is defined.
// Ports   : clk               - clock
//           reset             - async active-high reset (registered read only)
//           i_rdEn            - read strobe (registered read only)
//           i_wrEn/i_wrAddr/i_wrData - write port
//           i_rdAddr/o_rdData        - read port
// Options : SYNC_FIFO_FWFT_EN selects the asynchronous read port.
// ---------------------------------------------------------------------------
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = ptr_width(DEPTH)
) (
  input  logic                  clk,
`ifndef SYNC_FIFO_FWFT_EN
  input  logic                  reset,
  input  logic                  i_rdEn,
`endif
  input  logic                  i_wrEn,
  input  logic [AW-1:0]         i_wrAddr,
  input  logic [DATA_WIDTH-1:0] i_wrData,
  input  logic [AW-1:0]         i_rdAddr,
  output logic [DATA_WIDTH-1:0] o_rdData
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Storage is deliberately left unreset; the pointers guarantee that an
  // unwritten slot is never presented as valid data.
  always_ff @(posedge clk) begin
    if (i_wrEn) r_mem[i_wrAddr] <= i_wrData;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head entry is visible combinationally so the consumer sees it with no
  // read latency.
  assign o_rdData = r_mem[i_rdAddr];
`else
  logic [DATA_WIDTH-1:0] r_rdData;

  // Registered read: captures the head on the popping edge and holds it
  // until the next pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_rdData <= '0;
    else if (i_rdEn) r_rdData <= r_mem[i_rdAddr];
  end

  assign o_rdData = r_rdData;
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
// Purpose : parametrised single-clock FIFO with registered status flags,
//           occupancy count and overflow/underflow pulses.
// Ports   : clk   - clock, rising edge
//           reset - asynchronous, active-high
//           bus   - sync_fifo_param_if.slave (write/read handshake + status)
// Params  : DATA_WIDTH, DEPTH (power of two), AFULL_THRESH, AEMPTY_THRESH
// Options : SYNC_FIFO_FWFT_EN - first-word-fall-through read (rd_data shows
//           the head combinationally, rd_valid = ~empty). Undefined gives a
//           registered read with one cycle of latency.
// ---------------------------------------------------------------------------
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic               clk,
  input  logic               reset,
  sync_fifo_param_if.slave   bus
);

  localparam int AW = ptr_width(DEPTH);
  localparam int CW = count_width(DEPTH);

  if (!params_ok(DATA_WIDTH, DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_badParams
    $error("sync_fifo_param: illegal DEPTH/threshold parameter set");
  end

  logic [AW-1:0]         r_wrPtr;
  logic [AW-1:0]         r_rdPtr;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         w_countNext;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_almostFull;
  logic                  r_almostEmpty;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  w_wrAccept;
  logic                  w_rdAccept;
  logic [DATA_WIDTH-1:0] w_rdData;

  // Acceptance looks only at the registered flags, so a same-cycle pop can
  // never make room for a write to a full FIFO (and vice versa when empty).
  assign w_wrAccept = bus.wr_en & ~r_full;
  assign w_rdAccept = bus.rd_en & ~r_empty;

  // Occupancy moves by at most one; a simultaneous push and pop cancel out.
  always_comb begin
    w_countNext = r_count;
    if (w_wrAccept && !w_rdAccept)      w_countNext = r_count + CW'(1);
    else if (!w_wrAccept && w_rdAccept) w_countNext = r_count - CW'(1);
  end

  // Pointers wrap modulo DEPTH by natural overflow. Flags are derived from
  // the next count so they are exact right after the edge that changes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr       <= '0;
      r_rdPtr       <= '0;
      r_count       <= '0;
      r_full        <= 1'b0;
      r_empty       <= 1'b1;
      r_almostFull  <= 1'b0;
      r_almostEmpty <= 1'b1;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      if (w_wrAccept) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_rdAccept) r_rdPtr <= r_rdPtr + AW'(1);
      r_count       <= w_countNext;
      r_full        <= (w_countNext == CW'(DEPTH));
      r_empty       <= (w_countNext == '0);
      r_almostFull  <= (w_countNext >= CW'(AFULL_THRESH));
      r_almostEmpty <= (w_countNext <= CW'(AEMPTY_THRESH));
      r_overflow    <= bus.wr_en & r_full;
      r_underflow   <= bus.rd_en & r_empty;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk      (clk),
`ifndef SYNC_FIFO_FWFT_EN
    .reset    (reset),
    .i_rdEn   (w_rdAccept),
`endif
    .i_wrEn   (w_wrAccept),
    .i_wrAddr (r_wrPtr),
    .i_wrData (bus.wr_data),
    .i_rdAddr (r_rdPtr),
    .o_rdData (w_rdData)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.rd_valid = ~r_empty;
`else
  logic r_rdValid;

  // Marks the single cycle in which the registered rd_data holds a fresh pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rdValid <= 1'b0;
    else       r_rdValid <= w_rdAccept;
  end

  assign bus.rd_valid = r_rdValid;
`endif

  assign bus.rd_data      = w_rdData;
  assign bus.full         = r_full;
  assign bus.empty        = r_empty;
  assign bus.almost_full  = r_almostFull;
  assign bus.almost_empty = r_almostEmpty;
  assign bus.count        = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule
